miner_dispatch: RTL

MINER_DISPATCH -- requirements
Module: miner_dispatch

---
 rtl/miner_dispatch.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/miner_dispatch.sv
// miner_dispatch: broadcasts nonces to a bank of hashing cores and collects their hits.
// Hits wait in per-core pending registers and drain round-robin into a show-ahead result FIFO.
module miner_dispatch #(
    parameter int NUM_CORES  = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int HASH_W     = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        job_load,
    input  logic [31:0]                 job_nonce_start,
    input  logic [7:0]                  zero_bits,
    output logic [31:0]                 next_nonce,
    input  logic [NUM_CORES-1:0]        core_accepted,
    input  logic [NUM_CORES-1:0]        core_valid,
    input  logic [NUM_CORES*HASH_W-1:0] core_hash,
    input  logic [NUM_CORES*32-1:0]     core_nonce,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [HASH_W-1:0]           res_hash,
    output logic [31:0]                 res_nonce,
    output logic [7:0]                  drop_count,
    output logic                        nonce_wrapped
);
    localparam int            CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CORE = CW'(NUM_CORES - 1);

    logic [31:0]          nonce_q, nonce_d;
    logic                 wrap_q, wrap_d;
    logic [7:0]           drop_q, drop_d;
    logic [NUM_CORES-1:0] pend_q, pend_d;
    logic [CW-1:0]        rr_q, rr_d;
    logic [AW:0]          wr_q, wr_d;
    logic [AW:0]          rd_q, rd_d;

    logic [HASH_W-1:0]    pend_hash_q  [NUM_CORES];
    logic [31:0]          pend_nonce_q [NUM_CORES];
    logic [HASH_W-1:0]    fifo_hash_q  [FIFO_DEPTH];
    logic [31:0]          fifo_nonce_q [FIFO_DEPTH];

    logic [HASH_W-1:0]    zmask;
    logic [NUM_CORES-1:0] hit;
    logic [NUM_CORES-1:0] drained;
    logic [NUM_CORES-1:0] capture;
    logic                 grant_vld;
    logic [CW-1:0]        grant_idx;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_en;
    logic [4:0]           ndrop;
    logic [8:0]           drop_sum;

    // Bits at or above HASH_W-zero_bits must be zero; zero_bits >= HASH_W checks the whole hash.
    always_comb begin
        for (int j = 0; j < HASH_W; j++) begin
            zmask[j] = ((HASH_W - j) <= int'(zero_bits));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            hit[i] = core_valid[i] && !job_load
                     && ((core_hash[i*HASH_W +: HASH_W] & zmask) == '0);
        end
    end

    // Downward scan so the lowest offset from rr_q wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (pend_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(idx);
            end
        end
    end

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = ((wr_q - rd_q) == DEPTH_L);
    assign pop        = !job_load && !fifo_empty && res_ready;
    assign push_en    = !job_load && grant_vld && (!fifo_full || pop);

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            drained[i] = push_en && (grant_idx == CW'(i));
            capture[i] = hit[i] && (!pend_q[i] || drained[i]);
        end
    end

    always_comb begin
        nonce_d  = nonce_q;
        wrap_d   = wrap_q;
        drop_d   = drop_q;
        pend_d   = pend_q;
        rr_d     = rr_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        ndrop    = '0;
        drop_sum = '0;
        if (job_load) begin
            nonce_d = job_nonce_start;
            wrap_d  = 1'b0;
            drop_d  = '0;
            pend_d  = '0;
            rr_d    = '0;
            wr_d    = '0;
            rd_d    = '0;
        end else begin
            if (|core_accepted) begin
                nonce_d = nonce_q + 32'd1;
                if (nonce_q == 32'hFFFF_FFFF) begin
                    wrap_d = 1'b1;
                end
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (drained[i]) begin
                    pend_d[i] = 1'b0;
                end
                if (capture[i]) begin
                    pend_d[i] = 1'b1;
                end else if (hit[i]) begin
                    ndrop = ndrop + 5'd1;
                end
            end
            drop_sum = {1'b0, drop_q} + {4'd0, ndrop};
            drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (push_en) begin
                wr_d = wr_q + 1'b1;
                rr_d = (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q <= '0;
            wrap_q  <= 1'b0;
            drop_q  <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            nonce_q <= nonce_d;
            wrap_q  <= wrap_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Payload storage is qualified by pend_q / FIFO pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (capture[i]) begin
                pend_hash_q[i]  <= core_hash[i*HASH_W +: HASH_W];
                pend_nonce_q[i] <= core_nonce[i*32 +: 32];
            end
        end
        if (push_en) begin
            fifo_hash_q[wr_q[AW-1:0]]  <= pend_hash_q[grant_idx];
            fifo_nonce_q[wr_q[AW-1:0]] <= pend_nonce_q[grant_idx];
        end
    end

    assign next_nonce    = nonce_q;
    assign nonce_wrapped = wrap_q;
    assign drop_count    = drop_q;
    assign res_valid     = !fifo_empty;
    assign res_hash      = fifo_empty ? '0 : fifo_hash_q[rd_q[AW-1:0]];
    assign res_nonce     = fifo_empty ? '0 : fifo_nonce_q[rd_q[AW-1:0]];

endmodule
